// File: rtl/seq_table_fsm_if.sv
// Control/observation bundle for seq_table_fsm.
//   master : the front end (pushbutton/UART side) driving step/run/jump and table writes,
//            and observing state/outputs.
//   slave  : the sequencer itself.
// Signals:
//   step, run, jump, jump_state      advance and jump controls
//   wr_en, wr_addr, wr_next, wr_out  table write port (one entry per cycle)
//   state, next_state, out           current state and its table entries
//   home                             one-cycle pulse when an advance lands on the reset state
//   adv_count                        advances since reset, wrapping
interface seq_table_fsm_if #(
  parameter int unsigned STATE_W = 3,
  parameter int unsigned OUT_W   = 2,
  parameter int unsigned CNT_W   = 8
);
  logic               step;
  logic               run;
  logic               jump;
  logic [STATE_W-1:0] jump_state;
  logic               wr_en;
  logic [STATE_W-1:0] wr_addr;
  logic [STATE_W-1:0] wr_next;
  logic [OUT_W-1:0]   wr_out;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;
  logic [OUT_W-1:0]   out;
  logic               home;
  logic [CNT_W-1:0]   adv_count;

  modport master (
    output step, run, jump, jump_state, wr_en, wr_addr, wr_next, wr_out,
    input  state, next_state, out, home, adv_count
  );

  modport slave (
    input  step, run, jump, jump_state, wr_en, wr_addr, wr_next, wr_out,
    output state, next_state, out, home, adv_count
  );
endinterface

// File: rtl/seq_table_fsm.sv
// Table-driven sequencer. Next-state and per-state output tables are writable registers,
// so any sequence over 2^STATE_W states can be loaded at run time. The machine advances on
// a rising edge of step, every cycle while run is high, or jumps directly to jump_state.
// Ports:
//   hz100  clock, rising edge
//   reset  synchronous, active-low
//   bus    seq_table_fsm_if slave modport (controls, table write port, state/outputs)
// The interface instance must use the same STATE_W/OUT_W/CNT_W as this module.
module seq_table_fsm #(
  parameter int unsigned STATE_W     = 3,
  parameter int unsigned OUT_W       = 2,
  parameter int unsigned RESET_STATE = 3,
  parameter int unsigned CNT_W       = 8
) (
  input logic            hz100,
  input logic            reset,
  seq_table_fsm_if.slave bus
);

  localparam int unsigned NumStates = 2 ** STATE_W;
  localparam logic [STATE_W-1:0] HomeState = STATE_W'(RESET_STATE);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] next_tbl_q [NumStates];
  logic [OUT_W-1:0]   out_tbl_q  [NumStates];
  logic               step_q;
  logic               home_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               step_edge;
  logic               adv;
  logic [STATE_W-1:0] tbl_next;

  assign step_edge = bus.step & ~step_q;
  assign adv       = bus.run | step_edge;
  // Read before any same-edge write takes effect, so a colliding advance uses the old entry.
  assign tbl_next  = next_tbl_q[state_q];

  always_ff @(posedge hz100) begin
    if (!reset) begin
      state_q <= HomeState;
      // step_q starts high so a step held through reset is not taken as an edge.
      step_q  <= 1'b1;
      home_q  <= 1'b0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < NumStates; i++) begin
        next_tbl_q[STATE_W'(i)] <= STATE_W'(i + 1);
        out_tbl_q[STATE_W'(i)]  <= '0;
      end
    end else begin
      step_q <= bus.step;

      if (bus.wr_en) begin
        next_tbl_q[bus.wr_addr] <= bus.wr_next;
        out_tbl_q[bus.wr_addr]  <= bus.wr_out;
      end

      if (bus.jump) begin
        state_q <= bus.jump_state;
        home_q  <= 1'b0;
      end else if (adv) begin
        state_q <= tbl_next;
        cnt_q   <= cnt_q + CNT_W'(1);
        home_q  <= (tbl_next == HomeState);
      end else begin
        home_q  <= 1'b0;
      end
    end
  end

  assign bus.state      = state_q;
  assign bus.next_state = tbl_next;
  assign bus.out        = out_tbl_q[state_q];
  assign bus.home       = home_q;
  assign bus.adv_count  = cnt_q;

endmodule

// File: tb/tb_seq_table_fsm.sv
// Self-checking bench for seq_table_fsm: directed sequences, a vector table for the legacy
// sequence, and randomized stimulus checked every cycle against a behavioural model.
module tb_seq_table_fsm;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned OUT_W   = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int          RS      = 3;
  localparam int          NS      = 8;
  localparam int          CMOD    = 16;

  logic hz100;
  logic reset;

  seq_table_fsm_if #(.STATE_W(STATE_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

  seq_table_fsm #(
    .STATE_W    (STATE_W),
    .OUT_W      (OUT_W),
    .RESET_STATE(RS),
    .CNT_W      (CNT_W)
  ) dut (
    .hz100(hz100),
    .reset(reset),
    .bus  (bus)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: plain arrays indexed by state number.
  int m_next [NS];
  int m_out  [NS];
  int m_state;
  int m_cnt;
  int m_home;
  int m_stepq;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int nxt;
    int a;
    if (!reset) begin
      m_state = RS;
      for (int i = 0; i < NS; i++) begin
        m_next[i] = (i + 1) % NS;
        m_out[i]  = 0;
      end
      m_cnt   = 0;
      m_home  = 0;
      m_stepq = 1;
    end else begin
      nxt = m_next[m_state];
      a   = (bus.run || (bus.step && (m_stepq == 0))) ? 1 : 0;
      if (bus.jump) begin
        m_state = int'(bus.jump_state);
        m_home  = 0;
      end else if (a != 0) begin
        m_state = nxt;
        m_cnt   = (m_cnt + 1) % CMOD;
        m_home  = (nxt == RS) ? 1 : 0;
      end else begin
        m_home = 0;
      end
      if (bus.wr_en) begin
        m_next[bus.wr_addr] = int'(bus.wr_next);
        m_out[bus.wr_addr]  = int'(bus.wr_out);
      end
      m_stepq = bus.step ? 1 : 0;
    end
  endtask

  // One clock: advance model, wait for the edge, sample 1 time unit later, compare.
  task automatic tick();
    model_edge();
    @(posedge hz100);
    #1;
    check("model.state", int'(bus.state), m_state);
    check("model.next_state", int'(bus.next_state), m_next[m_state]);
    check("model.out", int'(bus.out), m_out[m_state]);
    check("model.home", int'(bus.home), m_home);
    check("model.adv_count", int'(bus.adv_count), m_cnt);
  endtask

  task automatic idle_inputs();
    bus.step       = 1'b0;
    bus.run        = 1'b0;
    bus.jump       = 1'b0;
    bus.jump_state = '0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_next    = '0;
    bus.wr_out     = '0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    reset = 1'b1;
  endtask

  typedef struct {
    logic step;
    int   exp_state;
    int   exp_out;
    int   exp_home;
    int   exp_cnt;
  } vec_t;

  vec_t vecs [16];
  int   legacy_next [NS];
  int   legacy_out  [NS];
  int   run_exp     [5];
  int   leg_seq     [8];

  initial begin
    legacy_next = '{1, 4, 7, 6, 3, 2, 5, 0};
    legacy_out  = '{3, 1, 0, 2, 2, 1, 1, 1};
    run_exp     = '{4, 5, 6, 7, 0};
    leg_seq     = '{6, 5, 2, 7, 0, 1, 4, 3};
    // Each step pulse is a high row then a low row.
    for (int k = 0; k < 8; k++) begin
      vecs[2*k]     = '{step: 1'b1, exp_state: leg_seq[k], exp_out: legacy_out[leg_seq[k]],
                        exp_home: (leg_seq[k] == RS) ? 1 : 0, exp_cnt: k + 1};
      vecs[2*k + 1] = '{step: 1'b0, exp_state: leg_seq[k], exp_out: legacy_out[leg_seq[k]],
                        exp_home: 0, exp_cnt: k + 1};
    end

    idle_inputs();
    reset = 1'b1;

    // Reset defaults.
    do_reset(2);
    check("rst.state", int'(bus.state), 3);
    check("rst.next_state", int'(bus.next_state), 4);
    check("rst.out", int'(bus.out), 0);
    check("rst.adv_count", int'(bus.adv_count), 0);
    check("rst.home", int'(bus.home), 0);

    bus.run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("run.state", int'(bus.state), run_exp[i]);
    end
    bus.run = 1'b0;

    // Legacy sequence load and step-driven walk.
    do_reset(1);
    for (int i = 0; i < NS; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = STATE_W'(i);
      bus.wr_next = STATE_W'(legacy_next[i]);
      bus.wr_out  = OUT_W'(legacy_out[i]);
      tick();
    end
    idle_inputs();
    check("load.state", int'(bus.state), 3);
    check("load.out", int'(bus.out), 2);
    for (int v = 0; v < 16; v++) begin
      bus.step = vecs[v].step;
      tick();
      check("vec.state", int'(bus.state), vecs[v].exp_state);
      check("vec.out", int'(bus.out), vecs[v].exp_out);
      check("vec.home", int'(bus.home), vecs[v].exp_home);
      check("vec.adv_count", int'(bus.adv_count), vecs[v].exp_cnt);
    end

    // Step held high: one advance only (3 -> 6).
    bus.step = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("hold.state", int'(bus.state), 6);
    check("hold.adv_count", int'(bus.adv_count), 9);

    // Step high through reset and after release: no advance.
    do_reset(2);
    for (int i = 0; i < 3; i++) tick();
    check("rststep.state", int'(bus.state), 3);
    check("rststep.adv_count", int'(bus.adv_count), 0);
    bus.step = 1'b0;
    tick();

    // Priority: jump beats run; same-edge write still lands.
    bus.jump       = 1'b1;
    bus.jump_state = 3'd5;
    bus.run        = 1'b1;
    bus.wr_en      = 1'b1;
    bus.wr_addr    = 3'd5;
    bus.wr_next    = 3'd1;
    bus.wr_out     = 2'd2;
    tick();
    check("prio.state", int'(bus.state), 5);
    check("prio.adv_count", int'(bus.adv_count), 0);
    idle_inputs();
    tick();
    check("prio.next_state", int'(bus.next_state), 1);
    check("prio.out", int'(bus.out), 2);
    check("prio.adv_count2", int'(bus.adv_count), 0);

    // Collision: advance from 2 while rewriting next_tbl[2] uses the old entry (3).
    bus.jump       = 1'b1;
    bus.jump_state = 3'd2;
    tick();
    idle_inputs();
    bus.run     = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd2;
    bus.wr_next = 3'd0;
    bus.wr_out  = 2'd1;
    tick();
    check("coll.state", int'(bus.state), 3);
    bus.wr_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();  // 4, 5, 1, 2
    check("coll.revisit", int'(bus.state), 2);
    tick();
    check("coll.new_next", int'(bus.state), 0);
    idle_inputs();

    // Counter wrap with a 4-bit counter.
    do_reset(1);
    bus.run = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    check("wrap.adv_count", int'(bus.adv_count), 1);
    idle_inputs();

    // Randomized stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      reset          = ($urandom_range(0, 79) != 0);
      bus.run        = ($urandom_range(0, 4) == 0);
      bus.step       = 1'($urandom_range(0, 1));
      bus.jump       = ($urandom_range(0, 9) == 0);
      bus.jump_state = STATE_W'($urandom_range(0, NS - 1));
      bus.wr_en      = ($urandom_range(0, 3) == 0);
      bus.wr_addr    = STATE_W'($urandom_range(0, NS - 1));
      bus.wr_next    = STATE_W'($urandom_range(0, NS - 1));
      bus.wr_out     = OUT_W'($urandom_range(0, 3));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_table_fsm.md
# seq_table_fsm

Parametrised, table-driven sequencer that succeeds the fixed 3-bit decoder/mux state machine. Both the next-state table and the per-state output table live in writable registers, so any sequence of up to 2^STATE_W states with OUT_W output bits per state can be loaded at run time. The machine advances on a debounced-button edge, free-runs every clock, or jumps directly to a state. It sits between the pushbutton/UART front end and the LED/seven-segment drivers in the top level.

## Interface
- STATE_W, 3, state width; the tables hold 2^STATE_W entries
- OUT_W, 2, output bits per state
- RESET_STATE, 3, state loaded on reset; must be less than 2^STATE_W
- CNT_W, 8, width of the advance counter
- hz100  in  1  clock; all logic is on the rising edge
- reset  in  1  synchronous, active-low reset
- step  in  1  single-step request as a level; the block detects its rising edge internally
- run  in  1  when 1, advance every cycle and ignore step
- jump  in  1  load jump_state into the state register
- jump_state  in  STATE_W  target of jump
- wr_en  in  1  write one table entry
- wr_addr  in  STATE_W  table index to write
- wr_next  in  STATE_W  next-state value to write
- wr_out  in  OUT_W  output value to write
- state  out  STATE_W  current state (registered)
- next_state  out  STATE_W  next_tbl[state] (combinational)
- out  out  OUT_W  out_tbl[state] (combinational)
- home  out  1  one-cycle registered pulse when an advance lands on RESET_STATE
- adv_count  out  CNT_W  number of advances since reset; wraps modulo 2^CNT_W

## Operation
- Reset (reset==0 at a rising edge):
  - state is set to RESET_STATE.
  - next_tbl[i] is set to (i+1) mod 2^STATE_W and out_tbl[i] is set to 0 for all i.
  - adv_count is set to 0 and home is set to 0.
  - The step edge register step_q is set to 1, so a step held high through reset produces no advance.
- Edge detection: step_q <= step every cycle; step_edge = step & ~step_q.
- The advance condition is adv = run | step_edge.
- State update priority:
  1. reset
  2. jump: state <= jump_state; not counted as an advance; home=0
  3. adv: state <= next_tbl[state]; adv_count += 1; home <= (next_tbl[state]==RESET_STATE)
  4. otherwise: hold, with home <= 0
- Table write: when wr_en is high, next_tbl[wr_addr] <= wr_next and out_tbl[wr_addr] <= wr_out on the same edge.
  - wr_en is honoured whenever reset is high, including during jump or adv.
- Write/advance collision: a simultaneous adv uses the pre-write table contents. The new entry is visible from the next cycle.
- next_state and out follow state and the tables combinationally. Writing the entry for the current state changes them in the cycle after the write.
- Unused and unreachable states need no special handling; every state follows its table entry.

## Timing
- Advance latency:
  - A step rise sampled at edge N sets state at edge N.
  - step must go low for at least one sampled cycle before it can advance again.
- With run=1 the block advances once per cycle. A length-L cycle in the table repeats every L clocks.
- jump has one-cycle latency.
- home is asserted exactly in the cycle after the advancing edge and lasts one cycle.
- Reset values:
  - state = RESET_STATE
  - next_state = (RESET_STATE+1) mod 2^STATE_W
  - out = 0
  - home = 0
  - adv_count = 0
- Reset mid-run: the next edge with reset low overrides jump, adv and wr_en. Table contents are lost.
- adv_count wrap: 2^CNT_W-1 advances to 0 with no flag.

## Test plan
- Reset defaults: hold reset low for 2 cycles, then release.
  - Required: state=3, next_state=4, out=0, adv_count=0, home=0.
  - Then 5 cycles with run=1 give state 4,5,6,7,0.
- Legacy sequence load: write next table {0:1, 1:4, 2:7, 3:6, 4:3, 5:2, 6:5, 7:0} and out table {0:3, 1:1, 2:0, 3:2, 4:2, 5:1, 6:1, 7:1}.
  - Advance with step pulses.
  - Required states: 3,6,5,2,7,0,1,4,3; out follows the table.
  - home pulses once, on the return to 3; adv_count=8.
- Step edge: hold step high for 10 cycles → exactly one advance. Assert step during reset and release with step still high → no advance.
- Priority: jump=1 with jump_state=5, run=1 and wr_en=1 at wr_addr=5 on the same edge.
  - Required: state=5 and the table entry is written.
  - Next cycle: next_state equals the new wr_next and adv_count is unchanged.
- Collision: from state 2, run=1 and write next_tbl[2]=0 on the same edge.
  - Required: state goes to the old next_tbl[2].
  - A later visit to state 2 goes to 0.
- Counter wrap (CNT_W=4): 17 advances → adv_count=1.
